// File: rtl/juego_pkg.sv
// Shared types for the game controller: FSM state codes, move directions and
// the button-priority helper.
package juego_pkg;

    localparam int unsigned ESTADO_W = 3;
    localparam int unsigned DIR_W    = 2;

    typedef enum logic [ESTADO_W-1:0] {
        INICIO    = 3'd0,
        ESPERA    = 3'd1,
        MOVER     = 3'd2,
        GENERAR   = 3'd3,
        VERIFICAR = 3'd4,
        GANADO    = 3'd5,
        PERDIDO   = 3'd6
    } estado_t;

    typedef enum logic [DIR_W-1:0] {
        DIR_IZQ = 2'd0,
        DIR_DER = 2'd1,
        DIR_ARR = 2'd2,
        DIR_ABA = 2'd3
    } dir_t;

    // Resolves simultaneous presses as izq > der > arr > aba; aba is the fallback.
    function automatic dir_t dir_prioridad(input logic izq, input logic der, input logic arr);
        dir_t d;
        if (izq)      d = DIR_IZQ;
        else if (der) d = DIR_DER;
        else if (arr) d = DIR_ARR;
        else          d = DIR_ABA;
        return d;
    endfunction

endpackage

// File: rtl/temporizador_espera.sv
// Watchdog for datapath handshakes: counts cycles spent in a waiting state and
// flags expiry on the LIMITE-th cycle. clear marks the first waiting cycle.
module temporizador_espera #(
    parameter int unsigned LIMITE = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expiro
);

    localparam int unsigned CNT_W = (LIMITE > 2) ? $clog2(LIMITE) : 1;
    localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(LIMITE - 1);

    logic [CNT_W-1:0] cuenta;

    // The clear cycle itself counts as waited cycle number one.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            cuenta <= '0;
        end else if (clear) begin
            cuenta <= CNT_W'(1);
        end else if (cuenta != ULTIMO) begin
            cuenta <= cuenta + CNT_W'(1);
        end
    end

    assign expiro = enable && !clear && (cuenta == ULTIMO);

endmodule

// File: rtl/control_juego.sv
// Game flow controller: sequences move, tile spawn and win/loss verification.
// Define CONTADOR_MOVS_EN to add the saturating move counter output movimientos.
module control_juego
    import juego_pkg::*;
#(
    parameter int unsigned TIMEOUT_CICLOS = 255,
    parameter int unsigned CONTADOR_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  btn_izq,
    input  logic                  btn_der,
    input  logic                  btn_arr,
    input  logic                  btn_aba,
    input  logic                  btn_reiniciar,
    output logic                  mov_start,
    output logic [DIR_W-1:0]      mov_dir,
    input  logic                  mov_done,
    input  logic                  mov_cambio,
    output logic                  gen_start,
    input  logic                  gen_done,
    output logic                  limpiar,
    input  logic                  gano_in,
    input  logic                  perdio_in,
    output logic                  gano,
    output logic                  perdio,
    output logic                  ocupado,
    output logic                  error_timeout,
`ifdef CONTADOR_MOVS_EN
    output logic [ESTADO_W-1:0]   estado,
    output logic [CONTADOR_W-1:0] movimientos
`else
    output logic [ESTADO_W-1:0]   estado
`endif
);

    if (TIMEOUT_CICLOS < 2 || CONTADOR_W < 1) begin : g_param_invalido
        $error("control_juego: TIMEOUT_CICLOS must be >= 2 and CONTADOR_W >= 1");
    end

    estado_t est;
    dir_t    dir;
    logic    wd_enable;
    logic    wd_expiro;

    assign estado    = est;
    assign mov_dir   = dir;
    assign wd_enable = (est == MOVER) || (est == GENERAR);

    // mov_start/gen_start are high exactly in the first cycle of each wait.
    temporizador_espera #(
        .LIMITE (TIMEOUT_CICLOS)
    ) u_temporizador (
        .clk    (clk),
        .rst    (rst),
        .clear  (mov_start | gen_start),
        .enable (wd_enable),
        .expiro (wd_expiro)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            est           <= INICIO;
            dir           <= DIR_IZQ;
            mov_start     <= 1'b0;
            gen_start     <= 1'b0;
            limpiar       <= 1'b0;
            gano          <= 1'b0;
            perdio        <= 1'b0;
            ocupado       <= 1'b0;
            error_timeout <= 1'b0;
`ifdef CONTADOR_MOVS_EN
            movimientos   <= '0;
`endif
        end else begin
            mov_start <= 1'b0;
            gen_start <= 1'b0;
            limpiar   <= 1'b0;
            case (est)
                INICIO: begin
                    limpiar   <= 1'b1;
                    gen_start <= 1'b1;
                    ocupado   <= 1'b1;
                    est       <= GENERAR;
`ifdef CONTADOR_MOVS_EN
                    movimientos <= '0;
`endif
                end
                ESPERA: begin
                    if (btn_reiniciar) begin
                        ocupado <= 1'b1;
                        est     <= INICIO;
                    end else if (btn_izq || btn_der || btn_arr || btn_aba) begin
                        dir       <= dir_prioridad(btn_izq, btn_der, btn_arr);
                        mov_start <= 1'b1;
                        ocupado   <= 1'b1;
                        est       <= MOVER;
                    end
                end
                MOVER: begin
                    // A done arriving on the expiry cycle still counts as on time.
                    if (mov_done) begin
                        if (mov_cambio) begin
                            gen_start <= 1'b1;
                            est       <= GENERAR;
`ifdef CONTADOR_MOVS_EN
                            if (movimientos != '1) begin
                                movimientos <= movimientos + CONTADOR_W'(1);
                            end
`endif
                        end else begin
                            ocupado <= 1'b0;
                            est     <= ESPERA;
                        end
                    end else if (wd_expiro) begin
                        error_timeout <= 1'b1;
                        ocupado       <= 1'b0;
                        est           <= ESPERA;
                    end
                end
                GENERAR: begin
                    if (gen_done) begin
                        est <= VERIFICAR;
                    end else if (wd_expiro) begin
                        error_timeout <= 1'b1;
                        ocupado       <= 1'b0;
                        est           <= ESPERA;
                    end
                end
                VERIFICAR: begin
                    ocupado <= 1'b0;
                    if (gano_in) begin
                        gano <= 1'b1;
                        est  <= GANADO;
                    end else if (perdio_in) begin
                        perdio <= 1'b1;
                        est    <= PERDIDO;
                    end else begin
                        est <= ESPERA;
                    end
                end
                GANADO, PERDIDO: begin
                    if (btn_reiniciar) begin
                        gano    <= 1'b0;
                        perdio  <= 1'b0;
                        ocupado <= 1'b1;
                        est     <= INICIO;
                    end
                end
                default: begin
                    ocupado <= 1'b1;
                    est     <= INICIO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_juego.sv
// Randomized self-checking bench for control_juego against a behavioural model
// of the game flow (state sequence, priority, move count, watchdog).
module tb_control_juego;

    localparam int unsigned TIMEOUT = 255;
    localparam int unsigned CW      = 16;

    logic clk           = 1'b0;
    logic rst           = 1'b1;
    logic btn_izq       = 1'b0;
    logic btn_der       = 1'b0;
    logic btn_arr       = 1'b0;
    logic btn_aba       = 1'b0;
    logic btn_reiniciar = 1'b0;
    logic mov_done      = 1'b0;
    logic mov_cambio    = 1'b0;
    logic gen_done      = 1'b0;
    logic gano_in       = 1'b0;
    logic perdio_in     = 1'b0;

    logic       mov_start;
    logic [1:0] mov_dir;
    logic       gen_start;
    logic       limpiar;
    logic       gano;
    logic       perdio;
    logic       ocupado;
    logic       error_timeout;
    logic [2:0] estado;
`ifdef CONTADOR_MOVS_EN
    logic [CW-1:0] movimientos;
`endif

    int   n_vec     = 0;
    int   n_err     = 0;
    int   movs_model = 0;
    logic et_model  = 1'b0;

    logic [9:0] obs;
    assign obs = {estado, mov_start, gen_start, limpiar, ocupado, gano, perdio, error_timeout};

    always #5 clk = ~clk;

    control_juego #(
        .TIMEOUT_CICLOS (TIMEOUT),
        .CONTADOR_W     (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_izq       (btn_izq),
        .btn_der       (btn_der),
        .btn_arr       (btn_arr),
        .btn_aba       (btn_aba),
        .btn_reiniciar (btn_reiniciar),
        .mov_start     (mov_start),
        .mov_dir       (mov_dir),
        .mov_done      (mov_done),
        .mov_cambio    (mov_cambio),
        .gen_start     (gen_start),
        .gen_done      (gen_done),
        .limpiar       (limpiar),
        .gano_in       (gano_in),
        .perdio_in     (perdio_in),
        .gano          (gano),
        .perdio        (perdio),
        .ocupado       (ocupado),
        .error_timeout (error_timeout),
`ifdef CONTADOR_MOVS_EN
        .estado        (estado),
        .movimientos   (movimientos)
`else
        .estado        (estado)
`endif
    );

    // Expected status word; busy/win/loss follow directly from the game state.
    function automatic logic [9:0] esperado(input int e, input logic ms, input logic gs,
                                            input logic lp, input logic et);
        logic oc;
        oc = !(e == 1 || e == 5 || e == 6);
        return {3'(e), ms, gs, lp, oc, (e == 5), (e == 6), et};
    endfunction

    // Lowest-numbered pressed button wins: b = {aba, arr, der, izq}.
    function automatic logic [1:0] prio(input logic [3:0] b);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) if (b[i]) r = 2'(i);
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_btn(input logic [3:0] b);
        {btn_aba, btn_arr, btn_der, btn_izq} = b;
        tick();
        {btn_aba, btn_arr, btn_der, btn_izq} = 4'b0;
    endtask

    task automatic test_reset;
        logic [9:0] want;
        rst = 1'b1;
        tick();
        tick();
        n_vec++;
        if (obs !== 10'b0) begin n_err++; $display("FAIL reset_outputs: got %b want %b", obs, 10'b0); end
        n_vec++;
        if (mov_dir !== 2'd0) begin n_err++; $display("FAIL reset_dir: got %0d want 0", mov_dir); end
        rst = 1'b0;
        tick();
        want = esperado(3, 1'b0, 1'b1, 1'b1, et_model);
        n_vec++;
        if (obs !== want) begin n_err++; $display("FAIL inicio_pulses: got %b want %b", obs, want); end
        tick();
        want = esperado(3, 1'b0, 1'b0, 1'b0, et_model);
        n_vec++;
        if (obs !== want) begin n_err++; $display("FAIL inicio_wait_gen: got %b want %b", obs, want); end
        gen_done = 1'b1;
        tick();
        gen_done = 1'b0;
        want = esperado(4, 1'b0, 1'b0, 1'b0, et_model);
        n_vec++;
        if (obs !== want) begin n_err++; $display("FAIL inicio_verificar: got %b want %b", obs, want); end
        tick();
        want = esperado(1, 1'b0, 1'b0, 1'b0, et_model);
        n_vec++;
        if (obs !== want) begin n_err++; $display("FAIL inicio_espera: got %b want %b", obs, want); end
    endtask

    // One full move from ESPERA; fin returns the state the model expects afterwards.
    task automatic test_move(input logic [3:0] b, input logic c, input int d, input logic stray,
                             input logic gi, input logic pi, output int fin);
        logic [9:0] want;
        logic [1:0] dir_exp;
        dir_exp = prio(b);
        pulse_btn(b);
        want = esperado(2, 1'b1, 1'b0, 1'b0, et_model);
        n_vec++;
        if (obs !== want) begin n_err++; $display("FAIL mov_entry: got %b want %b", obs, want); end
        n_vec++;
        if (mov_dir !== dir_exp) begin n_err++; $display("FAIL mov_dir: got %0d want %0d", mov_dir, dir_exp); end
        for (int i = 0; i < d; i++) begin
            if (stray) begin
                gen_done  = 1'($urandom);
                gano_in   = 1'($urandom);
                perdio_in = 1'($urandom);
                {btn_reiniciar, btn_aba, btn_arr, btn_der, btn_izq} = 5'($urandom);
            end
            tick();
            {gen_done, gano_in, perdio_in} = 3'b0;
            {btn_reiniciar, btn_aba, btn_arr, btn_der, btn_izq} = 5'b0;
            want = esperado(2, 1'b0, 1'b0, 1'b0, et_model);
            n_vec++;
            if (obs !== want) begin n_err++; $display("FAIL mov_wait: got %b want %b", obs, want); end
            n_vec++;
            if (mov_dir !== dir_exp) begin n_err++; $display("FAIL mov_dir_hold: got %0d want %0d", mov_dir, dir_exp); end
        end
        mov_done   = 1'b1;
        mov_cambio = c;
        tick();
        mov_done   = 1'b0;
        mov_cambio = 1'b0;
        if (!c) begin
            fin  = 1;
            want = esperado(1, 1'b0, 1'b0, 1'b0, et_model);
            n_vec++;
            if (obs !== want) begin n_err++; $display("FAIL mov_sin_cambio: got %b want %b", obs, want); end
        end else begin
            if (movs_model < (1 << CW) - 1) movs_model++;
            want = esperado(3, 1'b0, 1'b1, 1'b0, et_model);
            n_vec++;
            if (obs !== want) begin n_err++; $display("FAIL gen_entry: got %b want %b", obs, want); end
        end
`ifdef CONTADOR_MOVS_EN
        n_vec++;
        if (movimientos !== CW'(movs_model)) begin n_err++; $display("FAIL movs_after_move: got %0d want %0d", movimientos, movs_model); end
`endif
        if (c) begin
            for (int i = 0; i < d; i++) begin
                if (stray) begin
                    mov_done  = 1'($urandom);
                    gano_in   = 1'($urandom);
                    perdio_in = 1'($urandom);
                    {btn_reiniciar, btn_aba, btn_arr, btn_der, btn_izq} = 5'($urandom);
                end
                tick();
                {mov_done, gano_in, perdio_in} = 3'b0;
                {btn_reiniciar, btn_aba, btn_arr, btn_der, btn_izq} = 5'b0;
                want = esperado(3, 1'b0, 1'b0, 1'b0, et_model);
                n_vec++;
                if (obs !== want) begin n_err++; $display("FAIL gen_wait: got %b want %b", obs, want); end
            end
            gen_done = 1'b1;
            tick();
            gen_done = 1'b0;
            want = esperado(4, 1'b0, 1'b0, 1'b0, et_model);
            n_vec++;
            if (obs !== want) begin n_err++; $display("FAIL verificar: got %b want %b", obs, want); end
            gano_in   = gi;
            perdio_in = pi;
            tick();
            gano_in   = 1'b0;
            perdio_in = 1'b0;
            fin  = gi ? 5 : (pi ? 6 : 1);
            want = esperado(fin, 1'b0, 1'b0, 1'b0, et_model);
            n_vec++;
            if (obs !== want) begin n_err++; $display("FAIL verificar_exit: got %b want %b", obs, want); end
        end
    endtask

    task automatic test_reiniciar;
        logic [9:0] want;
        btn_reiniciar = 1'b1;
        tick();
        btn_reiniciar = 1'b0;
        want = esperado(0, 1'b0, 1'b0, 1'b0, et_model);
        n_vec++;
        if (obs !== want) begin n_err++; $display("FAIL reiniciar_inicio: got %b want %b", obs, want); end
        tick();
        movs_model = 0;
        want = esperado(3, 1'b0, 1'b1, 1'b1, et_model);
        n_vec++;
        if (obs !== want) begin n_err++; $display("FAIL reiniciar_limpiar: got %b want %b", obs, want); end
`ifdef CONTADOR_MOVS_EN
        n_vec++;
        if (movimientos !== CW'(movs_model)) begin n_err++; $display("FAIL movs_reiniciar: got %0d want %0d", movimientos, movs_model); end
`endif
        gen_done = 1'b1;
        tick();
        gen_done = 1'b0;
        tick();
        want = esperado(1, 1'b0, 1'b0, 1'b0, et_model);
        n_vec++;
        if (obs !== want) begin n_err++; $display("FAIL reiniciar_espera: got %b want %b", obs, want); end
    endtask

    task automatic test_prioridad;
        logic [9:0] want;
        int fin;
        mov_done = 1'b1;
        gen_done = 1'b1;
        tick();
        mov_done = 1'b0;
        gen_done = 1'b0;
        want = esperado(1, 1'b0, 1'b0, 1'b0, et_model);
        n_vec++;
        if (obs !== want) begin n_err++; $display("FAIL espera_ignora_done: got %b want %b", obs, want); end
        test_move(4'b1010, 1'b0, 3, 1'b0, 1'b0, 1'b0, fin);
        test_move(4'b1100, 1'b1, 2, 1'b0, 1'b0, 1'b0, fin);
    endtask

    task automatic test_random;
        int fin;
        for (int k = 0; k < 16; k++) begin
            test_move(4'($urandom_range(1, 15)), 1'($urandom), $urandom_range(0, 5), 1'b1,
                      ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0), fin);
            if (fin == 5 || fin == 6) test_reiniciar();
        end
    endtask

    task automatic test_sin_cambio;
        int fin;
        test_move(4'b0001, 1'b0, 0, 1'b0, 1'b0, 1'b0, fin);
        test_move(4'b0001, 1'b1, 0, 1'b0, 1'b0, 1'b0, fin);
        test_move(4'b1000, 1'b0, 1, 1'b1, 1'b0, 1'b0, fin);
        test_reiniciar();
    endtask

    task automatic test_timeout;
        logic [9:0] want;
        int n;
        int fin;
        pulse_btn(4'b0100);
        n_vec++;
        if (error_timeout !== et_model) begin n_err++; $display("FAIL timeout_pre: got %0b want %0b", error_timeout, et_model); end
        n = 0;
        while (n < int'(TIMEOUT) + 20) begin
            btn_reiniciar = (n == 7);
            tick();
            btn_reiniciar = 1'b0;
            n++;
            if (estado !== 3'd2) break;
        end
        et_model = 1'b1;
        n_vec++;
        if (n != int'(TIMEOUT)) begin n_err++; $display("FAIL timeout_mover_cycles: got %0d want %0d", n, TIMEOUT); end
        want = esperado(1, 1'b0, 1'b0, 1'b0, et_model);
        n_vec++;
        if (obs !== want) begin n_err++; $display("FAIL timeout_mover: got %b want %b", obs, want); end
        pulse_btn(4'b0010);
        mov_done   = 1'b1;
        mov_cambio = 1'b1;
        tick();
        mov_done   = 1'b0;
        mov_cambio = 1'b0;
        if (movs_model < (1 << CW) - 1) movs_model++;
        n = 0;
        while (n < int'(TIMEOUT) + 20) begin
            tick();
            n++;
            if (estado !== 3'd3) break;
        end
        n_vec++;
        if (n != int'(TIMEOUT)) begin n_err++; $display("FAIL timeout_gen_cycles: got %0d want %0d", n, TIMEOUT); end
        want = esperado(1, 1'b0, 1'b0, 1'b0, et_model);
        n_vec++;
        if (obs !== want) begin n_err++; $display("FAIL timeout_gen: got %b want %b", obs, want); end
        test_move(4'b0001, 1'b1, 1, 1'b0, 1'b0, 1'b0, fin);
    endtask

    task automatic test_ganar;
        logic [9:0] want;
        int fin;
        test_move(4'b0001, 1'b1, 2, 1'b0, 1'b1, 1'b1, fin);
        pulse_btn(4'b0010);
        mov_done = 1'b1;
        gen_done = 1'b1;
        tick();
        mov_done = 1'b0;
        gen_done = 1'b0;
        want = esperado(5, 1'b0, 1'b0, 1'b0, et_model);
        n_vec++;
        if (obs !== want) begin n_err++; $display("FAIL ganado_hold: got %b want %b", obs, want); end
        test_reiniciar();
        test_move(4'b0010, 1'b1, 1, 1'b0, 1'b0, 1'b1, fin);
        pulse_btn(4'b0001);
        want = esperado(6, 1'b0, 1'b0, 1'b0, et_model);
        n_vec++;
        if (obs !== want) begin n_err++; $display("FAIL perdido_hold: got %b want %b", obs, want); end
        test_reiniciar();
    endtask

    task automatic test_reset_generar;
        logic [9:0] want;
        pulse_btn(4'b0100);
        mov_done   = 1'b1;
        mov_cambio = 1'b1;
        tick();
        mov_done   = 1'b0;
        mov_cambio = 1'b0;
        tick();
        rst = 1'b1;
        gen_done = 1'b1;
        tick();
        rst = 1'b0;
        gen_done = 1'b0;
        et_model   = 1'b0;
        movs_model = 0;
        n_vec++;
        if (obs !== 10'b0) begin n_err++; $display("FAIL rst_gen_outputs: got %b want %b", obs, 10'b0); end
        n_vec++;
        if (mov_dir !== 2'd0) begin n_err++; $display("FAIL rst_gen_dir: got %0d want 0", mov_dir); end
`ifdef CONTADOR_MOVS_EN
        n_vec++;
        if (movimientos !== CW'(movs_model)) begin n_err++; $display("FAIL rst_gen_movs: got %0d want %0d", movimientos, movs_model); end
`endif
        tick();
        want = esperado(3, 1'b0, 1'b1, 1'b1, et_model);
        n_vec++;
        if (obs !== want) begin n_err++; $display("FAIL rst_gen_inicio: got %b want %b", obs, want); end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL bench_time_limit: got no finish want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_prioridad();
        test_random();
        test_sin_cambio();
        test_timeout();
        test_ganar();
        test_reset_generar();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
